// File: rtl/int_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : int_regfile_sb
// Description : Integer register file with a per-register pending-write
//               scoreboard. Two combinational read ports (data + busy), one
//               synchronous writeback port that also releases a pending
//               count, and an allocation port that reserves a pending count.
//               Register 0 is hardwired to zero and never busy.
//               Optional macro: REGFILE_BYPASS_EN forwards same-cycle
//               writeback data (and the post-release busy) onto the reads.
// Revision    : 1.0 - initial release
// ============================================================================
module int_regfile_sb #(
  parameter  int XLEN   = 64,
  parameter  int NREGS  = 32,
  parameter  int PEND_W = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   read_addr_a,
  input  logic [AW-1:0]   read_addr_b,
  output logic [XLEN-1:0] read_data_a,
  output logic [XLEN-1:0] read_data_b,
  output logic            read_busy_a,
  output logic            read_busy_b,
  input  logic            write_enable,
  input  logic [AW-1:0]   write_addr,
  input  logic [XLEN-1:0] write_data,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_addr,
  output logic            alloc_ready
);

  // Saturation value of a pending counter: no further allocation allowed.
  localparam logic [PEND_W-1:0] c_MAX = {PEND_W{1'b1}};

  // Flattened view of every register and counter (entry 0 is constant zero).
  logic [XLEN-1:0]   w_data [NREGS];
  logic [PEND_W-1:0] w_cnt  [NREGS];

  logic w_alloc_ready;
  logic w_alloc_fire;

  // Readiness looks only at the stored count; a same-cycle write to a
  // saturated register does not open a slot for the allocation.
  assign w_alloc_ready = (alloc_addr == '0) || (w_cnt[alloc_addr] != c_MAX);
  assign w_alloc_fire  = alloc_valid && w_alloc_ready;
  assign alloc_ready   = w_alloc_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_data[gi] = '0;
        assign w_cnt[gi]  = '0;
      end else begin : g_live
        logic [XLEN-1:0]   r_data;
        logic [PEND_W-1:0] r_cnt;
        logic [PEND_W-1:0] w_cnt_nxt;
        logic              w_wr_hit;
        logic              w_al_hit;

        assign w_wr_hit = write_enable && (write_addr == AW'(gi));
        assign w_al_hit = w_alloc_fire && (alloc_addr == AW'(gi));

        // Next pending count: allocate increments, writeback releases, and a
        // simultaneous pair nets to zero except from an idle count, where the
        // release has nothing to cancel and the allocation must still count.
        always_comb begin
          w_cnt_nxt = r_cnt;
          if (w_al_hit && w_wr_hit) begin
            w_cnt_nxt = (r_cnt == '0) ? PEND_W'(1) : r_cnt;
          end else if (w_al_hit) begin
            w_cnt_nxt = r_cnt + PEND_W'(1);
          end else if (w_wr_hit && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - PEND_W'(1);
          end
        end

        // Architectural value storage, updated on writeback.
        always_ff @(posedge clock or negedge reset) begin
          if (!reset) begin
            r_data <= '0;
          end else if (w_wr_hit) begin
            r_data <= write_data;
          end
        end

        // Pending-writer counter storage.
        always_ff @(posedge clock or negedge reset) begin
          if (!reset) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end

        assign w_data[gi] = r_data;
        assign w_cnt[gi]  = r_cnt;
      end
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic w_byp_a;
  logic w_byp_b;

  // Forwarding is suppressed during reset so the ports read zero there.
  assign w_byp_a = reset && write_enable && (write_addr != '0) && (write_addr == read_addr_a);
  assign w_byp_b = reset && write_enable && (write_addr != '0) && (write_addr == read_addr_b);

  // A forwarded read reports the busy state after this write's release.
  assign read_data_a = w_byp_a ? write_data : w_data[read_addr_a];
  assign read_data_b = w_byp_b ? write_data : w_data[read_addr_b];
  assign read_busy_a = w_byp_a ? (w_cnt[read_addr_a] > PEND_W'(1)) : (w_cnt[read_addr_a] != '0);
  assign read_busy_b = w_byp_b ? (w_cnt[read_addr_b] > PEND_W'(1)) : (w_cnt[read_addr_b] != '0);
`else
  // Reads show stored state only; writes appear the cycle after the edge.
  assign read_data_a = w_data[read_addr_a];
  assign read_data_b = w_data[read_addr_b];
  assign read_busy_a = (w_cnt[read_addr_a] != '0);
  assign read_busy_b = (w_cnt[read_addr_b] != '0);
`endif

endmodule
`default_nettype wire
